// File: rtl/branch_ctrl_pkg.sv
// Shared branch definitions: BranchType codes, controller state encoding, BHT reset value.
// Also consumed by the control unit and the EX branch comparator.
package branch_ctrl_pkg;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_BEQ  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b010;
   localparam logic [2:0] BR_BGEZ = 3'b100;
   localparam logic [2:0] BR_BNE  = 3'b101;
   localparam logic [2:0] BR_BLEZ = 3'b110;
   localparam logic [2:0] BR_BGTZ = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_REDIR = 1'b1
   } state_t;

   // Weak not-taken
   localparam logic [1:0] BHT_RESET = 2'b01;

   function automatic logic isBranch(input logic [2:0] brType);
      case (brType)
         BR_BEQ, BR_BLT, BR_BGEZ, BR_BNE, BR_BLEZ, BR_BGTZ: isBranch = 1'b1;
         default:                                          isBranch = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/branch_bht.sv
// 2-bit saturating counter history table; async read port (IF), sync update port (EX).
// Read has no write bypass: an update becomes visible the cycle after the edge.
module branch_bht
   import branch_ctrl_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] rdIdx,
   output logic [1:0]    rdCtr,
   input  logic          updEn,
   input  logic [AW-1:0] updIdx,
   input  logic          updTaken
);

   logic [1:0] ctrs [2**AW];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2**AW; i++) ctrs[i] <= BHT_RESET;
      end else if (updEn) begin
         if (updTaken && ctrs[updIdx] != 2'b11)
            ctrs[updIdx] <= ctrs[updIdx] + 2'd1;
         else if (!updTaken && ctrs[updIdx] != 2'b00)
            ctrs[updIdx] <= ctrs[updIdx] - 2'd1;
      end
   end

   assign rdCtr = ctrs[rdIdx];

endmodule

// File: rtl/branch_ctrl.sv
// Branch predict + mispredict recovery; redirect/flush registered 1 cycle after EX resolution.
// Stall holds REDIR and blocks resolution; BHT prediction only when BRANCH_PREDICT_EN is defined.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int BHT_AW = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [31:0]      if_pc,
   input  logic             if_is_branch,
   input  logic [31:0]      if_target,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   input  logic [2:0]       ex_branch_type,
   input  logic             ex_compare,
   input  logic [31:0]      ex_pc,
   input  logic [31:0]      ex_target,
   input  logic             ex_pred_taken,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic             flush,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   state_t state;
   logic   resolve;
   logic   actual;
   logic   mispredict;
   logic   unusedSink;

   // Only the instruction in EX while IDLE and unstalled is resolved; REDIR means EX is wrong-path.
   assign resolve = (state == ST_IDLE) && !stall && isBranch(ex_branch_type);
   assign actual  = ex_compare;

`ifdef BRANCH_PREDICT_EN
   logic [1:0] ifCtr;

   branch_bht #(.AW(BHT_AW)) uBht (
      .clk      (clk),
      .reset    (reset),
      .rdIdx    (if_pc[BHT_AW+1:2]),
      .rdCtr    (ifCtr),
      .updEn    (resolve),
      .updIdx   (ex_pc[BHT_AW+1:2]),
      .updTaken (actual)
   );

   assign pred_taken = if_is_branch && ifCtr[1];
   assign mispredict = actual != ex_pred_taken;
   assign unusedSink = ^{ifCtr[0], if_pc[31:BHT_AW+2], if_pc[1:0]};
`else
   // Static not-taken: any taken branch is a mispredict.
   assign pred_taken = 1'b0;
   assign mispredict = actual;
   assign unusedSink = ^{if_pc, if_is_branch, ex_pred_taken};
`endif

   assign pred_target = pred_taken ? if_target : 32'd0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         redirect    <= 1'b0;
         flush       <= 1'b0;
         redirect_pc <= 32'd0;
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (resolve) begin
                  if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
                  if (mispredict) begin
                     state       <= ST_REDIR;
                     redirect    <= 1'b1;
                     flush       <= 1'b1;
                     redirect_pc <= actual ? ex_target : ex_pc + 32'd4;
                     if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
                  end
               end
            end
            ST_REDIR: begin
               if (!stall) begin
                  state    <= ST_IDLE;
                  redirect <= 1'b0;
                  flush    <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
